// File: rtl/mmcm_unlock_monitor.sv
// mmcm_unlock_monitor
// Tracks lock loss on NUM_CH MMCM channels. Each channel counts unlocked
// cycles in its live counter. It posts the length of every completed
// unlock episode into a one-entry pending slot. A round-robin arbiter
// drains the slots into a single valid/ready record output.
// Optional build macro: LOCK_SYNC_EN puts a 2-flop synchronizer on each
// locked input. Without the macro, locked is used directly.
module mmcm_unlock_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       mmcm_rstn,
  input  logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH*CNT_W-1:0] live_cnt,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [CH_W-1:0]         rec_ch,
  output logic [CNT_W-1:0]        rec_dur,
  output logic [NUM_CH-1:0]       ovf,
  input  logic                    clr_ovf
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_UNLK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  // Saturating increment: a counter at its maximum stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) r = v;
    else              r = v + CNT_ONE;
    return r;
  endfunction

  // Index of the lowest set bit (0 when no bit is set).
  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = CH_ZERO;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_W'(i);
      else        idx = idx;
    end
    return idx;
  endfunction

  logic [NUM_CH-1:0] locked_s;
  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] emit_s;
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]  pend_dur_q [NUM_CH];
  logic [CNT_W-1:0]  pend_dur_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              out_vld_q, out_vld_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CNT_W-1:0]  out_dur_q, out_dur_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] hi_s, free_s;
  logic              gnt_vld_s, load_s;
  logic [CH_W-1:0]   gnt_idx_s;

`ifdef LOCK_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // Synchronizer stage inputs.
  always_comb begin
    sync1_d = locked;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer for the asynchronous lock indications.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= {NUM_CH{1'b0}};
      sync2_q <= {NUM_CH{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign locked_s = sync2_q;
`else
  assign locked_s = locked;
`endif

  // Per-channel episode FSM and duration counter. mmcm_rstn low overrides everything.
  always_comb begin
    emit_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!mmcm_rstn[i]) begin
        state_d[i] = ST_RST;
        cnt_d[i]   = CNT_ZERO;
      end else begin
        case (state_q[i])
          ST_RST: begin
            state_d[i] = ST_ACQ;
            cnt_d[i]   = CNT_ZERO;
          end
          ST_ACQ, ST_UNLK: begin
            if (locked_s[i]) begin
              state_d[i] = ST_LOCK;
              emit_s[i]  = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
          ST_LOCK: begin
            if (!locked_s[i]) begin
              state_d[i] = ST_UNLK;
              cnt_d[i]   = CNT_ONE;
            end else begin
              state_d[i] = ST_LOCK;
            end
          end
          default: begin
            state_d[i] = ST_RST;
            cnt_d[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Round-robin pick among pending slots, searching upward from rr_ptr_q.
  always_comb begin
    hi_s      = pend_vld_q & ({NUM_CH{1'b1}} << rr_ptr_q);
    gnt_vld_s = |pend_vld_q;
    if (|hi_s) gnt_idx_s = first_set(hi_s);
    else       gnt_idx_s = first_set(pend_vld_q);
  end

  // The output register refills when empty or when its record is taken this edge.
  always_comb begin
    load_s    = !out_vld_q || rec_ready;
    out_vld_d = out_vld_q;
    out_ch_d  = out_ch_q;
    out_dur_d = out_dur_q;
    rr_ptr_d  = rr_ptr_q;
    free_s    = {NUM_CH{1'b0}};
    if (load_s) begin
      if (gnt_vld_s) begin
        out_vld_d         = 1'b1;
        out_ch_d          = gnt_idx_s;
        out_dur_d         = pend_dur_q[gnt_idx_s];
        free_s[gnt_idx_s] = 1'b1;
        if (gnt_idx_s == LAST_CH) rr_ptr_d = CH_ZERO;
        else                      rr_ptr_d = gnt_idx_s + CH_ONE;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Pending slots: accept a new record unless occupied and not drained this edge.
  // In that case the new record is dropped and ovf is flagged.
  always_comb begin
    if (clr_ovf) ovf_d = {NUM_CH{1'b0}};
    else         ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_vld_d[i] = pend_vld_q[i];
      pend_dur_d[i] = pend_dur_q[i];
      if (emit_s[i]) begin
        if (pend_vld_q[i] && !free_s[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_vld_d[i] = 1'b1;
          pend_dur_d[i] = cnt_q[i];
        end
      end else if (free_s[i]) begin
        pend_vld_d[i] = 1'b0;
      end else begin
        pend_vld_d[i] = pend_vld_q[i];
      end
    end
  end

  // Channel state, counters and pending slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= ST_RST;
        cnt_q[i]      <= CNT_ZERO;
        pend_dur_q[i] <= CNT_ZERO;
      end
      pend_vld_q <= {NUM_CH{1'b0}};
      ovf_q      <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        pend_dur_q[i] <= pend_dur_d[i];
      end
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output record register and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q <= 1'b0;
      out_ch_q  <= CH_ZERO;
      out_dur_q <= CNT_ZERO;
      rr_ptr_q  <= CH_ZERO;
    end else begin
      out_vld_q <= out_vld_d;
      out_ch_q  <= out_ch_d;
      out_dur_q <= out_dur_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Flatten the live counters onto the output bus.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      live_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign rec_valid = out_vld_q;
  assign rec_ch    = out_ch_q;
  assign rec_dur   = out_dur_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mmcm_unlock_monitor.sv
// Testbench for mmcm_unlock_monitor (NUM_CH=4, CNT_W=8). A behavioural
// model runs alongside the DUT and is compared every cycle. The stimulus
// is directed scenarios followed by a randomized phase.
module tb_mmcm_unlock_monitor;

  localparam int NC   = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;
`ifdef LOCK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [NC-1:0] mmcm_rstn;
  logic [NC-1:0] locked;
  logic [NC*CW-1:0] live_cnt;
  logic          rec_valid;
  logic          rec_ready;
  logic [1:0]    rec_ch;
  logic [CW-1:0] rec_dur;
  logic [NC-1:0] ovf;
  logic          clr_ovf;

  mmcm_unlock_monitor #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .mmcm_rstn(mmcm_rstn), .locked(locked),
    .live_cnt(live_cnt), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_ch(rec_ch), .rec_dur(rec_dur), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          m_run [NC];   // channel left reset
  bit          m_lkd [NC];   // channel has a lock established
  int unsigned m_cnt [NC];
  bit          m_pv  [NC];
  int unsigned m_pd  [NC];
  bit [NC-1:0] m_ovf;
  bit          m_ov_v;
  int          m_och;
  int unsigned m_odur;
  int          m_ptr;
  bit          m_s1 [NC];
  bit          m_s2 [NC];

  bit cap_en = 1'b0;
  int seen_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 1'b0; m_lkd[i] = 1'b0; m_cnt[i] = 0;
      m_pv[i] = 1'b0; m_pd[i] = 0; m_s1[i] = 1'b0; m_s2[i] = 1'b0;
    end
    m_ovf = '0; m_ov_v = 1'b0; m_och = 0; m_odur = 0; m_ptr = 0;
  endtask

  // One clock edge of the behavioural model, from the current inputs.
  task automatic model_step();
    bit          ld;
    int          g;
    bit [NC-1:0] freed;
    bit          ls;
    ld = !m_ov_v || rec_ready;
    g = -1;
    for (int k = 0; k < NC; k++) begin
      int idx;
      idx = (m_ptr + k) % NC;
      if (g < 0 && m_pv[idx]) g = idx;
    end
    freed = '0;
    if (ld) begin
      if (g >= 0) begin
        m_ov_v = 1'b1; m_och = g; m_odur = m_pd[g];
        m_ptr = (g + 1) % NC; freed[g] = 1'b1;
      end else begin
        m_ov_v = 1'b0;
      end
    end
    if (clr_ovf) m_ovf = '0;
    for (int i = 0; i < NC; i++) begin
      bit          emit;
      int unsigned edur;
      emit = 1'b0; edur = 0;
      ls = (LAT == 2) ? m_s2[i] : locked[i];
      if (!mmcm_rstn[i]) begin
        m_run[i] = 1'b0; m_lkd[i] = 1'b0; m_cnt[i] = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1'b1; m_lkd[i] = 1'b0; m_cnt[i] = 0;
      end else if (!ls) begin
        if (m_lkd[i]) begin
          m_lkd[i] = 1'b0; m_cnt[i] = 1;
        end else if (m_cnt[i] < CMAX) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else if (!m_lkd[i]) begin
        emit = 1'b1; edur = m_cnt[i]; m_lkd[i] = 1'b1;
      end
      if (emit) begin
        if (m_pv[i] && !freed[i]) m_ovf[i] = 1'b1;
        else begin m_pv[i] = 1'b1; m_pd[i] = edur; end
      end else if (freed[i]) begin
        m_pv[i] = 1'b0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = locked[i];
    end
  endtask

  task automatic compare_all();
    logic [NC*CW-1:0] el;
    for (int i = 0; i < NC; i++) el[i*CW +: CW] = CW'(m_cnt[i]);
    check_val("live_cnt", live_cnt, el);
    check_val("rec_valid", rec_valid, m_ov_v);
    if (m_ov_v) begin
      check_val("rec_ch", rec_ch, m_och);
      check_val("rec_dur", rec_dur, m_odur);
    end
    check_val("ovf", ovf, m_ovf);
  endtask

  task automatic tick();
    if (cap_en && rec_valid && rec_ready) seen_q.push_back(int'(rec_ch));
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rstn = 1'b0; mmcm_rstn = '0; locked = '0; rec_ready = 1'b1; clr_ovf = 1'b0;
    model_reset();
    #12;
    compare_all();
    check_val("rst_live", live_cnt, 32'd0);
    rstn = 1'b1;
    tick(); tick();

    // Channel 0 acquires lock after 10 unlocked cycles in ACQ.
    mmcm_rstn[0] = 1'b1;
    tick();
    repeat (10) tick();
    locked[0] = 1'b1;
    repeat (4) tick();
    check_val("acq_live0", live_cnt[7:0], 8'(10 + LAT));

    // Channel 1 loses lock for 5 cycles.
    mmcm_rstn[1] = 1'b1; locked[1] = 1'b1;
    repeat (6) tick();
    locked[1] = 1'b0;
    repeat (5) tick();
    locked[1] = 1'b1;
    repeat (6) tick();
    check_val("unlk_live1", live_cnt[15:8], 8'd5);

    // Channel 2 saturates its counter.
    mmcm_rstn[2] = 1'b1;
    repeat (300) tick();
    check_val("sat_live2", live_cnt[23:16], 8'd255);
    locked[2] = 1'b1;
    repeat (6) tick();
    check_val("sat_hold2", live_cnt[23:16], 8'd255);

    // Channel 3: three episodes while the consumer stalls -> third dropped.
    mmcm_rstn[3] = 1'b1; locked[3] = 1'b1;
    repeat (8) tick();
    rec_ready = 1'b0;
    locked[3] = 1'b0; repeat (3) tick();
    locked[3] = 1'b1; repeat (3) tick();
    locked[3] = 1'b0; repeat (4) tick();
    locked[3] = 1'b1; repeat (3) tick();
    locked[3] = 1'b0; repeat (2) tick();
    locked[3] = 1'b1; repeat (6) tick();
    check_val("stall_valid", rec_valid, 1'b1);
    check_val("stall_ch", rec_ch, 2'd3);
    check_val("stall_dur", rec_dur, 8'd3);
    check_val("stall_ovf3", ovf[3], 1'b1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check_val("clr_ovf3", ovf[3], 1'b0);
    rec_ready = 1'b1;
    repeat (4) tick();

    // All channels relock on the same edge -> records in order 0,1,2,3.
    locked = 4'b0000; repeat (5) tick();
    cap_en = 1'b1;
    locked = 4'b1111; repeat (8) tick();
    cap_en = 1'b0;
    check_val("rr_count", seen_q.size(), 4);
    for (int i = 0; i < seen_q.size() && i < 4; i++) check_val("rr_order", seen_q[i], i);

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(7) == 0) locked[i] = ~locked[i];
        mmcm_rstn[i] = ($urandom_range(63) != 0);
      end
      rec_ready = ($urandom_range(3) != 0);
      clr_ovf   = ($urandom_range(31) == 0);
      tick();
    end
    clr_ovf = 1'b0;

    // Global reset in the middle of an unlock episode with a record pending.
    rec_ready = 1'b0; mmcm_rstn = 4'hF; locked = 4'hF;
    repeat (6) tick();
    locked[1] = 1'b0; repeat (4) tick();
    locked[1] = 1'b1; repeat (3) tick();
    locked[1] = 1'b0; repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("arst_live", live_cnt, 32'd0);
    check_val("arst_valid", rec_valid, 1'b0);
    check_val("arst_dur", rec_dur, 8'd0);
    locked = 4'h0; rec_ready = 1'b1;
    #1;
    rstn = 1'b1;
    repeat (6) tick();
    check_val("post_rst_valid", rec_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
